// File: rtl/scan_mux.sv
// scan_mux: registered N-channel W-bit multiplexer with manual select and auto-scan rotation.
module scan_mux #(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [CHANNELS*WIDTH-1:0]   data_in,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        mode,
  input  logic                        hold,
  output logic [WIDTH-1:0]            data_out,
  output logic [SEL_W-1:0]            cur_sel,
  output logic                        valid,
  output logic                        wrap
);
  typedef enum logic [1:0] {MANUAL, SCAN, FROZEN} state_t;
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  localparam logic [SEL_W-1:0] TOP = SEL_W'(CHANNELS - 1);
  state_t r_state, w_next_state;
  logic [CW-1:0] r_cnt, w_next_cnt;
  logic [SEL_W-1:0] r_cur_sel, w_base, w_next_sel;
  logic [WIDTH-1:0] r_data, w_ch;
  logic r_valid, r_wrap, w_step, w_wrap, w_hit;
  assign data_out = r_data;
  assign cur_sel = r_cur_sel;
  assign valid = r_valid;
  assign wrap = r_wrap;
  always_ff @(posedge clock)
    r_state <= reset ? MANUAL : w_next_state;
  always_comb begin
    w_next_state = hold ? FROZEN : mode ? SCAN : MANUAL;
    // a scan entered after an out-of-range manual select restarts at channel 0
    w_base = (r_state != SCAN && !r_valid) ? '0 : r_cur_sel;
    w_step = w_next_state == SCAN && r_cnt == LAST;
    w_wrap = w_step && w_base == TOP;
    w_next_sel = w_next_state == MANUAL ? sel : !w_step ? w_base : w_wrap ? '0 : w_base + 1'b1;
    w_next_cnt = (w_next_state == SCAN && !w_step) ? r_cnt + 1'b1 : '0;
    w_ch = '0;
    w_hit = 1'b0;
    for (int k = 0; k < CHANNELS; k++)
      if (w_next_sel == SEL_W'(k)) begin
        w_ch = data_in[k*WIDTH +: WIDTH];
        w_hit = 1'b1;
      end
  end
  always_ff @(posedge clock)
    if (reset) begin
      r_cnt <= '0;
      r_cur_sel <= '0;
      r_data <= '0;
      r_valid <= 1'b0;
      r_wrap <= 1'b0;
    end else if (w_next_state == FROZEN) begin
      r_wrap <= 1'b0;
    end else begin
      r_cnt <= w_next_cnt;
      r_wrap <= w_wrap;
      r_valid <= w_hit;
      r_data <= w_ch;
      if (w_hit) r_cur_sel <= w_next_sel;
    end
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: random stimulus into two scan_mux configurations, scoreboarded against a cycle-level reference model.
module tb_scan_mux;
  typedef struct {logic [3:0] d; logic [1:0] s; logic v; logic w;} exp_t;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, mode, hold;
  logic [15:0] din;
  logic [1:0] sel;
  logic [3:0] d0, d1;
  logic [1:0] s0, s1;
  logic v0, v1, w0, w1;
  int n_chk = 0, n_fail = 0;
  exp_t q0[$], q1[$];
  exp_t e;
  int m_cur[2], m_rem[2];
  logic m_v[2], m_w[2];
  logic [3:0] m_d[2];
  scan_mux #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(3)) u0 (
    .clock(clk), .reset(rst), .data_in(din), .sel(sel), .mode(mode), .hold(hold),
    .data_out(d0), .cur_sel(s0), .valid(v0), .wrap(w0));
  scan_mux #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(1)) u1 (
    .clock(clk), .reset(rst), .data_in(din[11:0]), .sel(sel), .mode(mode), .hold(hold),
    .data_out(d1), .cur_sel(s1), .valid(v1), .wrap(w1));
  // m_rem = edges left on the current channel before the scan moves on
  task automatic model(input int c, input int nch, input int dw);
    if (rst) begin
      m_cur[c] = 0; m_v[c] = 0; m_d[c] = 0; m_w[c] = 0; m_rem[c] = dw;
    end else if (hold) begin
      m_w[c] = 0;
    end else if (!mode) begin
      m_rem[c] = dw; m_w[c] = 0;
      m_v[c] = int'(sel) < nch;
      if (m_v[c]) m_cur[c] = int'(sel);
      m_d[c] = m_v[c] ? din[int'(sel)*4 +: 4] : 4'd0;
    end else begin
      if (!m_v[c]) m_cur[c] = 0;
      m_w[c] = 0;
      m_rem[c] = m_rem[c] - 1;
      if (m_rem[c] == 0) begin
        m_rem[c] = dw;
        m_w[c] = m_cur[c] == nch - 1;
        m_cur[c] = m_w[c] ? 0 : m_cur[c] + 1;
      end
      m_v[c] = 1;
      m_d[c] = din[m_cur[c]*4 +: 4];
    end
    if (c == 0) q0.push_back('{d: m_d[c], s: 2'(m_cur[c]), v: m_v[c], w: m_w[c]});
    else q1.push_back('{d: m_d[c], s: 2'(m_cur[c]), v: m_v[c], w: m_w[c]});
  endtask
  task automatic cyc();
    model(0, 4, 3);
    model(1, 3, 1);
    @(negedge clk);
  endtask
  task automatic chk(input string n, input logic [3:0] a, input logic [3:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, x, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("u0.data_out", d0, e.d);
      chk("u0.cur_sel", {2'b0, s0}, {2'b0, e.s});
      chk("u0.valid", {3'b0, v0}, {3'b0, e.v});
      chk("u0.wrap", {3'b0, w0}, {3'b0, e.w});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("u1.data_out", d1, e.d);
      chk("u1.cur_sel", {2'b0, s1}, {2'b0, e.s});
      chk("u1.valid", {3'b0, v1}, {3'b0, e.v});
      chk("u1.wrap", {3'b0, w1}, {3'b0, e.w});
    end
  end
  initial begin
    rst = 1; mode = 1; hold = 1; sel = 0; din = 16'hDCBA;
    cyc(); cyc();
    rst = 0; mode = 0; hold = 0;
    cyc();
    sel = 2; cyc();
    din[11:8] = 4'h5; cyc();
    sel = 0; cyc();
    din[11:8] = 4'hC;
    mode = 1; repeat (26) cyc();
    hold = 1; repeat (5) begin din = 16'($urandom); cyc(); end
    hold = 0; din = 16'hDCBA; repeat (6) cyc();
    mode = 0; sel = 3; repeat (2) cyc();
    mode = 1; repeat (6) cyc();
    rst = 1; cyc();
    rst = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(199) == 0;
      if ($urandom_range(24) == 0) mode = ~mode;
      if ($urandom_range(9) == 0) hold = ~hold;
      if ($urandom_range(3) == 0) din = 16'($urandom);
      if ($urandom_range(5) == 0) sel = 2'($urandom);
      cyc();
    end
    @(posedge clk);
    #2;
    chk("scoreboard.drained", 4'(q0.size() + q1.size()), 4'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised, registered N-channel, W-bit multiplexer.
- Next generation of the lab 2:1 selector: adds channel count, bus width, registered output, and an auto-scan mode that steps through channels with a programmable dwell time.
- Sits between switch/data sources and LED/display outputs, so one output bus can show several sources either manually or in rotation.

Parameters:
- WIDTH, 4: bits per channel; WIDTH ≥ 1.
- CHANNELS, 4: number of input channels; CHANNELS ≥ 2.
- SEL_W, 2: select width; must satisfy 2^SEL_W ≥ CHANNELS.
- DWELL, 4: clock cycles spent on each channel in scan mode; DWELL ≥ 1.

Ports:
- clock  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- data_in  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  manual channel select
- mode  in  1  0 = manual, 1 = auto-scan
- hold  in  1  1 = freeze all state and outputs
- data_out  out  WIDTH  registered selected channel
- cur_sel  out  SEL_W  channel currently driven on data_out
- valid  out  1  data_out holds a legal channel's data
- wrap  out  1  one-cycle pulse when scan wraps from last channel to channel 0

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values: data_out=0, cur_sel=0, valid=0, wrap=0, dwell counter=0, state=MANUAL. Reset has priority over hold and mode.
- FSM states are MANUAL, SCAN and FROZEN. The state is evaluated every edge with this priority: reset, then hold, then mode.
  - hold=1: enter FROZEN.
  - hold=0 and mode=0: enter MANUAL.
  - hold=0 and mode=1: enter SCAN.
- Output register rule: on every non-FROZEN edge, compute next_sel, then load cur_sel<=next_sel and data_out<=data_in[next_sel*WIDTH +: WIDTH].
  - data_out therefore has 1-cycle latency from data_in and from sel.
  - cur_sel and data_out always describe the same channel.
- MANUAL:
  - next_sel=sel and valid<=1.
  - If sel ≥ CHANNELS: data_out<=0, valid<=0, cur_sel unchanged.
  - Dwell counter is held at 0.
- SCAN:
  - The dwell counter counts 0..DWELL-1.
  - While count < DWELL-1: count increments and next_sel=cur_sel.
  - At count = DWELL-1: count<=0 and next_sel=cur_sel+1. If cur_sel=CHANNELS-1, next_sel=0 and wrap<=1 for exactly that cycle.
  - valid<=1 throughout.
  - With DWELL=1, the channel advances every cycle.
- Mode switches:
  - MANUAL→SCAN: scan starts from the current cur_sel with the counter at 0. If the last manual select was out of range, scan starts at channel 0.
  - SCAN→MANUAL: the counter clears and sel takes effect on the same edge.
- FROZEN:
  - data_out, cur_sel, valid and the dwell counter hold their values; wrap<=0.
  - data_in and sel changes are ignored.
  - On release, operation resumes mid-dwell: the remaining dwell cycles are preserved, not restarted.
- wrap is 0 on every cycle except the wrap edge. It is never asserted in MANUAL or FROZEN.
- Counter width is max(1, ceil(log2(DWELL))). The design has no combinational path from inputs to outputs.

Test Plan:
- Setup for all scenarios unless stated: WIDTH=4, CHANNELS=4, DWELL=3, data_in={D,C,B,A} (channel 3 = D, channel 0 = A).
- Reset: assert reset for 2 cycles with mode=1 and hold=1 → data_out=0, cur_sel=0, valid=0, wrap=0; the first post-reset edge with mode=0 and sel=0 gives data_out=A, valid=1.
- Manual: mode=0, sel=2 → next edge data_out=C, cur_sel=2. Then set channel 2 to 5 → data_out=5 exactly one cycle later. Then sel=0 → data_out=A one cycle later.
- Scan/wrap: mode=1 from cur_sel=0 → data_out=A,A,A,B,B,B,C,C,C,D,D,D,A. wrap=1 only on the D→A cycle. Repeat over two full rotations.
- Hold mid-dwell: in scan, assert hold=1 after the first cycle on B, for 5 cycles, while changing data_in → data_out stays B and wrap=0. Release → B for 2 more cycles, then C.
- Out-of-range: CHANNELS=3, SEL_W=2, mode=0, sel=3 → data_out=0, valid=0, cur_sel retains its previous value. Then mode=1 → scan starts at channel 0.
- DWELL=1 and reset mid-scan: with DWELL=1, data_out advances every cycle and wrap pulses every 4th cycle. Asserting reset mid-rotation returns all outputs to their reset values on the next edge.
